// File: rtl/volume_pkg.sv
// Shared types and helpers for the volume meter.
// Holds the FSM state encoding and the thermometer bar-count function.
package volume_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        AVERAGE,
        UPDATE
    } state_t;

    // Bars lit for a magnitude: MSB position shifted so the top bar
    // corresponds to the top magnitude bit, clamped to [0, levels].
    function automatic int therm(
        input logic [31:0] avg,
        input int          m,
        input int          levels
    );
        int p;
        int n;
        p = 0;
        for (int i = 0; i < 32; i++) begin
            if (avg[i]) p = i;
        end
        n = p + 1 - (m - levels);
        if (n < 0) n = 0;
        if (n > levels) n = levels;
        if (avg == '0) n = 0;
        return n;
    endfunction

endpackage

// File: rtl/volume_abs.sv
// Saturating absolute value of a signed sample, W bits in, W-1 bits out.
// The most negative code maps to the largest positive magnitude.
module volume_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] sample,
    output logic [W-2:0] mag
);

    logic [W-1:0] neg;

    assign neg = ~sample + {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        mag = sample[W-2:0];
        if (sample[W-1]) begin
            if (sample[W-2:0] == '0) mag = '1;
            else                     mag = neg[W-2:0];
        end
    end

endmodule

// File: rtl/volume_meter.sv
// Windowed audio level meter: average magnitude plus thermometer bars.
// Optional peak-hold bars are enabled by defining VOLUME_PEAK_HOLD_EN.
module volume_meter
    import volume_pkg::*;
#(
    parameter int W            = 8,
    parameter int LOG2_WINDOW  = 8,
    parameter int LEVELS       = 6,
    parameter int HOLD_WINDOWS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      sample,
    input  logic              start,
    output logic              finish,
    output logic [W-2:0]      avg,
    output logic [LEVELS-1:0] level,
    output logic              level_valid,
    output logic [LEVELS-1:0] peak
);

    localparam int M = W - 1;
    localparam int L = LOG2_WINDOW;
    localparam logic [L-1:0] CNT_ONE = 1;
    localparam logic [L-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_d;

    logic [M-1:0]   mag;
    logic [M-1:0]   abs_q;
    logic [M+L-1:0] sum;
    logic [L-1:0]   count;
    int             n_cur;

    function automatic logic [LEVELS-1:0] bars(input int n);
        logic [LEVELS-1:0] b;
        for (int i = 0; i < LEVELS; i++) begin
            b[LEVELS-1-i] = (i < n);
        end
        return b;
    endfunction

    volume_abs #(.W(W)) u_abs (
        .sample(sample),
        .mag   (mag)
    );

    assign finish = (state == IDLE);
    assign n_cur  = therm(32'(avg), M, LEVELS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   state_d = (count == CNT_MAX) ? AVERAGE : IDLE;
            AVERAGE: state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abs_q       <= '0;
            sum         <= '0;
            count       <= '0;
            avg         <= '0;
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) abs_q <= mag;
                end
                ACCUM: begin
                    sum   <= sum + {{L{1'b0}}, abs_q};
                    count <= count + CNT_ONE;
                end
                AVERAGE: begin
                    avg <= sum[M+L-1:L];
                end
                UPDATE: begin
                    level       <= bars(n_cur);
                    level_valid <= 1'b1;
                    sum         <= '0;
                    count       <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef VOLUME_PEAK_HOLD_EN
    localparam int PW = $clog2(LEVELS + 1);
    localparam int HW = (HOLD_WINDOWS < 1) ? 1 : $clog2(HOLD_WINDOWS + 1);
    localparam logic [HW-1:0] HOLD_ONE = 1;

    logic [PW-1:0] peak_n;
    logic [HW-1:0] hold;
    int            pn_nx;
    logic [HW-1:0] hold_nx;

    // A new higher level restarts the hold; afterwards decay one bar per window.
    always_comb begin
        pn_nx   = int'(peak_n);
        hold_nx = hold;
        if (n_cur > int'(peak_n)) begin
            pn_nx   = n_cur;
            hold_nx = '0;
        end else if (int'(hold) < HOLD_WINDOWS) begin
            hold_nx = hold + HOLD_ONE;
        end else if (peak_n != '0) begin
            pn_nx = int'(peak_n) - 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_n <= '0;
            hold   <= '0;
            peak   <= '0;
        end else if (state == UPDATE) begin
            peak_n <= PW'(pn_nx);
            hold   <= hold_nx;
            peak   <= bars(pn_nx);
        end
    end
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_volume_meter.sv
// Self-checking bench for volume_meter against a behavioural window model.
// Checks every cycle's level_valid and the outputs at each window update.
module tb_volume_meter;

    localparam int W      = 8;
    localparam int LW     = 8;
    localparam int LEVELS = 6;
    localparam int HOLD   = 2;
    localparam int M      = W - 1;
    localparam int WIN    = 1 << LW;

    logic              clk = 1'b0;
    logic              reset;
    logic [W-1:0]      sample;
    logic              start;
    logic              finish;
    logic [M-1:0]      avg;
    logic [LEVELS-1:0] level;
    logic              level_valid;
    logic [LEVELS-1:0] peak;

    always #5 clk = ~clk;

    volume_meter #(
        .W(W), .LOG2_WINDOW(LW), .LEVELS(LEVELS), .HOLD_WINDOWS(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .sample(sample), .start(start),
        .finish(finish), .avg(avg), .level(level),
        .level_valid(level_valid), .peak(peak)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int msum, mcnt;
    int valid_cyc = -1;
    int e_avg, e_level, e_peak;
    int pk_n, pk_hold;

    function automatic int sat_abs(int v);
        if (v >= 0) return v;
        if (-v > (1 << M) - 1) return (1 << M) - 1;
        return -v;
    endfunction

    function automatic int bar_n(int a);
        int p, n;
        if (a == 0) return 0;
        p = 0;
        while ((1 << (p + 1)) <= a) p++;
        n = p + 1 - (M - LEVELS);
        if (n < 0) n = 0;
        if (n > LEVELS) n = LEVELS;
        return n;
    endfunction

    function automatic int bars(int n);
        return ((1 << n) - 1) << (LEVELS - n);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_accept(int v);
        int n;
        msum += sat_abs(v);
        mcnt++;
        if (mcnt == WIN) begin
            e_avg   = msum / WIN;
            n       = bar_n(e_avg);
            e_level = bars(n);
`ifdef VOLUME_PEAK_HOLD_EN
            if (n > pk_n) begin
                pk_n    = n;
                pk_hold = 0;
            end else if (pk_hold < HOLD) begin
                pk_hold++;
            end else if (pk_n > 0) begin
                pk_n--;
            end
            e_peak = bars(pk_n);
`else
            e_peak = 0;
`endif
            valid_cyc = cyc + 4;
            msum = 0;
            mcnt = 0;
        end
    endtask

    task automatic tick();
        if (start && finish && !reset) model_accept(int'($signed(sample)));
        @(negedge clk);
        cyc++;
        chk("level_valid", level_valid, cyc == valid_cyc);
        if (cyc == valid_cyc) begin
            chk("avg", avg, e_avg);
            chk("level", level, e_level);
            chk("peak", peak, e_peak);
        end
    endtask

    task automatic push(int v);
        bit acc;
        sample = v[W-1:0];
        start  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            acc = finish;
            tick();
            if (acc) return;
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        start     = 1'b0;
        reset     = 1'b1;
        msum      = 0;
        mcnt      = 0;
        valid_cyc = -1;
        pk_n      = 0;
        pk_hold   = 0;
        tick();
        chk("rst_finish", finish, 1);
        chk("rst_avg", avg, 0);
        chk("rst_level", level, 0);
        chk("rst_peak", peak, 0);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int acc, nt;
        logic [LEVELS-1:0] pk_exp [5];
        reset  = 1'b1;
        start  = 1'b0;
        sample = '0;
        #2;
        do_reset();

        // Constant window
        for (int i = 0; i < WIN; i++) push(16);
        idle(6);
        chk("const_avg", avg, 16);
        chk("const_level", level, 6'b111100);

        // Alternating sign and most-negative saturation
        for (int i = 0; i < WIN; i++) push((i % 2) ? -16 : 16);
        idle(6);
        chk("alt_avg", avg, 16);
        chk("alt_level", level, 6'b111100);
        for (int i = 0; i < WIN; i++) push(-128);
        idle(6);
        chk("sat_avg", avg, 127);
        chk("sat_level", level, 6'b111111);

        // Start held high with random samples
        start = 1'b1;
        acc = 0;
        nt = 0;
        while (acc < WIN && nt < 2000) begin
            sample = W'($urandom);
            if (finish) acc++;
            tick();
            nt++;
        end
        chk("held_ticks", nt, 2 * WIN - 1);
        idle(6);

        // Reset mid-window
        for (int i = 0; i < 100; i++) push(127);
        do_reset();
        for (int i = 0; i < WIN; i++) push(8);
        idle(6);
        chk("rst_mid_avg", avg, 8);
        chk("rst_mid_level", level, 6'b111000);

        // Random samples with random gaps
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WIN; i++) begin
                push(int'($signed(W'($urandom))));
                idle($urandom_range(0, 2));
            end
            idle(6);
        end

        // Peak hold and decay
        do_reset();
        pk_exp = '{6'b111111, 6'b111111, 6'b111111, 6'b111110, 6'b111100};
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < WIN; i++) push(w == 0 ? 64 : 0);
            idle(6);
            chk("peak_lvl", level, w == 0 ? 6'b111111 : 6'b000000);
`ifdef VOLUME_PEAK_HOLD_EN
            chk("peak_seq", peak, pk_exp[w]);
`else
            chk("peak_off", peak, 0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
